// File: rtl/scroll_ctrl_if.sv
// Purpose : bundles the scroll sequencer's control, lookup and window signals.
// Latency : none; this is wiring only.
// Backpress: none; the controls are level/pulse inputs and there is no handshake.
// Ports   : en/step/dir/restart (controls), rom_addr/rom_data (digit lookup),
//           window/valid/head (display side).
// Modports: master = the sequencer, slave = its environment (switches, lookup, display).
interface scroll_ctrl_if #(
    parameter int WIN_DIGITS = 4
);
    logic                      en;
    logic                      step;
    logic                      dir;
    logic                      restart;
    logic [3:0]                rom_addr;
    logic [3:0]                rom_data;
    logic [4*WIN_DIGITS-1:0]   window;
    logic                      valid;
    logic [3:0]                head;

    modport master (
        input  en, step, dir, restart, rom_data,
        output rom_addr, window, valid, head
    );

    modport slave (
        output en, step, dir, restart, rom_data,
        input  rom_addr, window, valid, head
    );
endinterface

// File: rtl/scroll_ctrl.sv
// Purpose : scrolls a MSG_LEN-digit message through a WIN_DIGITS-wide window
//           by walking a combinational digit lookup, paced by a prescaler.
// Latency : rom_addr is combinational; window/valid/head update on the step edge.
// Backpress: none; en pauses scrolling, and step pulses are taken only while paused.
// Ports   : clk, rst_n (async active-low), bus (scroll_ctrl_if.master).
// Optional: define SCROLL_BOUNCE_EN to replace the dir input with an internal
//           ping-pong direction. The window then bounces between the message
//           ends and never wraps.
module scroll_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int WIN_DIGITS = 4,
    parameter int MSG_LEN    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    scroll_ctrl_if.master bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    FILL_LAST  = 4'(WIN_DIGITS - 1);
    localparam logic [3:0]    IDX_LAST   = 4'(MSG_LEN - 1);
    localparam int            WW         = 4 * WIN_DIGITS;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t         state_q;
    logic [3:0]     fill_cnt_q;
    logic [PW-1:0]  presc_q;
    logic [WW-1:0]  window_q;
    logic           valid_q;
    logic [3:0]     head_q;

    logic           dir_eff;
    logic           can_step;
    logic           do_step;
    logic [4:0]     fwd_sum;
    logic [3:0]     fwd_addr;
    logic [3:0]     bwd_addr;
    logic [3:0]     head_inc;
    logic [3:0]     head_dec;
    logic [WW+3:0]  shl_ext;
    logic [WW+3:0]  shr_ext;

`ifdef SCROLL_BOUNCE_EN
    localparam logic [3:0] BOUNCE_TOP = 4'(MSG_LEN - WIN_DIGITS);
    logic bdir_q;
    assign dir_eff  = bdir_q;
    // A window covering the whole message has nowhere to move.
    assign can_step = (MSG_LEN != WIN_DIGITS);
`else
    assign dir_eff  = bus.dir;
    assign can_step = 1'b1;
`endif

    // Modulo-MSG_LEN index arithmetic uses explicit compares, so a
    // non-power-of-two message length also wraps correctly.
    assign fwd_sum  = {1'b0, head_q} + 5'(WIN_DIGITS);
    assign fwd_addr = (fwd_sum >= 5'(MSG_LEN)) ? 4'(fwd_sum - 5'(MSG_LEN)) : fwd_sum[3:0];
    assign bwd_addr = (head_q == 4'd0) ? IDX_LAST : head_q - 4'd1;
    assign head_inc = (head_q == IDX_LAST) ? 4'd0 : head_q + 4'd1;
    assign head_dec = bwd_addr;

    // Widened copies let the same slices serve both shift directions for any
    // WIN_DIGITS, including a single-digit window.
    assign shl_ext = {window_q, bus.rom_data};
    assign shr_ext = {bus.rom_data, window_q};

    // Outside FILL, rom_addr always points at the digit the next step will
    // consume. A step's data is therefore already present on its edge.
    assign bus.rom_addr = (state_q == FILL) ? fill_cnt_q
                        : (dir_eff ? bwd_addr : fwd_addr);

    // In RUN, a falling en takes priority over a due tick, and the prescaler
    // holds its value. A step pulse coinciding with en=1 in PAUSE is dropped.
    assign do_step = can_step && !bus.restart &&
                     (((state_q == RUN)   && bus.en && (presc_q == PRESC_LAST)) ||
                      ((state_q == PAUSE) && !bus.en && bus.step));

    assign bus.window = window_q;
    assign bus.valid  = valid_q;
    assign bus.head   = head_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            fill_cnt_q <= 4'd0;
            presc_q    <= '0;
            window_q   <= '0;
            valid_q    <= 1'b0;
            head_q     <= 4'd0;
`ifdef SCROLL_BOUNCE_EN
            bdir_q     <= 1'b0;
`endif
        end else if (bus.restart) begin
            // The window is left as is; the refill overwrites every digit.
            state_q    <= FILL;
            fill_cnt_q <= 4'd0;
            presc_q    <= '0;
            valid_q    <= 1'b0;
            head_q     <= 4'd0;
`ifdef SCROLL_BOUNCE_EN
            bdir_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    window_q   <= shl_ext[WW-1:0];
                    fill_cnt_q <= fill_cnt_q + 4'd1;
                    if (fill_cnt_q == FILL_LAST) begin
                        valid_q <= 1'b1;
                        state_q <= bus.en ? RUN : PAUSE;
                    end
                end
                RUN: begin
                    if (!bus.en) begin
                        state_q <= PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_q <= '0;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (bus.en) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= FILL;
            endcase

            if (do_step) begin
                if (!dir_eff) begin
                    window_q <= shl_ext[WW-1:0];
                    head_q   <= head_inc;
`ifdef SCROLL_BOUNCE_EN
                    if (head_inc == BOUNCE_TOP) begin
                        bdir_q <= 1'b1;
                    end
`endif
                end else begin
                    window_q <= shr_ext[WW+3:4];
                    head_q   <= head_dec;
`ifdef SCROLL_BOUNCE_EN
                    if (head_dec == 4'd0) begin
                        bdir_q <= 1'b0;
                    end
`endif
                end
            end
        end
    end
endmodule

// File: doc/scroll_ctrl.md
Name: scroll_ctrl

Overview:
- Sequencer that drives the 4-bit-index message lookup (index in, hex digit out) to scroll a 16-digit message across a WIN_DIGITS-wide seven-segment window.
- Generates lookup addresses, captures the returned digits into a window shift register, and paces scrolling with a prescaler.
- Supports run/pause, single-step and direction control.
- Sits between the board switches/buttons and the seven-segment digit multiplexer.

Parameters:
- TICK_DIV, 50000000: clock cycles per scroll step; must be >= 2.
- WIN_DIGITS, 4: digits visible in the window; range 1..MSG_LEN.
- MSG_LEN, 16: message length in digits; range 2..16. Lookup address width is fixed at 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  1 = auto-scroll, 0 = paused
- step  in  1  single-cycle pulse; one scroll step while paused
- dir  in  1  0 = forward (window moves toward higher indices), 1 = backward
- restart  in  1  synchronous; re-enter FILL with head = 0
- rom_addr  out  4  lookup index, combinational from state and registers
- rom_data  in  4  lookup digit, combinational, valid in the same cycle
- window  out  4*WIN_DIGITS  displayed digits; MS nibble = leftmost = index head
- valid  out  1  window fully loaded
- head  out  4  index of the leftmost digit

Behaviour:
- Reset (rst_n low, asynchronous):
  - window = 0, valid = 0, head = 0.
  - Fill counter = 0, prescaler = 0, state = FILL.
- States: FILL, RUN, PAUSE.
- FILL:
  - rom_addr = fill counter.
  - Each cycle: window shifts left 4 bits, rom_data enters the LS nibble, and the fill counter increments.
  - After WIN_DIGITS cycles: valid = 1, and the next state is RUN if en = 1, else PAUSE.
  - en, step and dir are ignored during FILL.
- Index arithmetic: all indices wrap modulo MSG_LEN. Implement with an explicit compare, not bit truncation.
- Step operation:
  - Forward (dir = 0): rom_addr = head + WIN_DIGITS. Window shifts left 4 bits, rom_data enters the LS nibble, head = head + 1.
  - Backward (dir = 1): rom_addr = head - 1. Window shifts right 4 bits, rom_data enters the MS nibble, head = head - 1.
  - Outside a step cycle, rom_addr shows the address of the next step.
- RUN:
  - Prescaler counts 0..TICK_DIV-1.
  - When it is at TICK_DIV-1: perform a step on that edge and reset the prescaler to 0.
  - The first step occurs TICK_DIV cycles after entering RUN.
  - en = 0 moves to PAUSE on the next edge with the prescaler held (not cleared).
- PAUSE:
  - step = 1 performs exactly one step that cycle; the prescaler is untouched.
  - en = 1 returns to RUN and resumes the prescaler from its held value.
  - step asserted in the same cycle as en = 1 is ignored.
- Direction changes: dir is sampled only on step cycles. Changing dir never corrupts the window, because the window always equals digits head..head+WIN_DIGITS-1.
- restart:
  - Has priority over everything except reset.
  - Next edge: valid = 0, head = 0, fill counter = 0, prescaler = 0, state = FILL. The window is not cleared and is overwritten by the refill.
- Reset mid-operation returns to the reset values immediately; there is no partial-step state.
- valid stays 1 except during reset and FILL.

Optional Feature:
- Macro: SCROLL_BOUNCE_EN
- Defined:
  - The dir input is ignored and an internal direction register (reset 0) is used.
  - After a forward step that makes head = MSG_LEN - WIN_DIGITS, the register flips to backward.
  - After a backward step that makes head = 0, it flips to forward.
  - No wrap-around ever occurs.
  - If WIN_DIGITS = MSG_LEN, no steps occur.
- Undefined: the direction follows dir and indices wrap as specified above.

Test Plan:
Bench uses TICK_DIV = 4, WIN_DIGITS = 4, MSG_LEN = 16, and the team lookup digits A,A,C,0,F,F,E,E,A,1,5,A,9,0,0,D for indices 0..15.
1. Reset, en = 1 -> valid = 0 and window = 0x0000 during reset; 4 cycles after release, window = 0xAAC0, valid = 1, head = 0.
2. Continue RUN, dir = 0 -> window = 0xAC0F, head = 1 exactly 4 cycles after valid rose; after 13 total steps, head = 13, window = 0x00DA (wrap verified).
3. After fill, dir = 1, en = 1 -> first step gives head = 15, window = 0xDAAC.
4. en = 0 at head = 1 -> window stays constant for 20 cycles; one step pulse -> head = 2, window = 0xC0FF; step together with en = 1 -> ignored.
5. assert restart during RUN at head = 7 -> valid = 0 next cycle; 4 cycles later, window = 0xAAC0, head = 0. Pull rst_n low mid-FILL -> all outputs return to reset values immediately.
6. With SCROLL_BOUNCE_EN -> head runs 0..12 forward, then 11..0 backward, then forward again; never wraps; dir toggling has no effect.
